// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - pipelined signed multiply-accumulate with rounded, saturated output
//
// Four-stage, no-back-pressure MAC. Beats are qualified by in_valid; in_first
// starts a new sum, in_last closes it and requests one output word.
//
//   Stage 1: register operands and beat flags
//   Stage 2: full-precision signed product
//   Stage 3: accumulator (load on first, add otherwise, wraps modulo 2^WL_ACC)
//   Stage 4: round-half-up by SHIFT, saturate to WL_OUT, register result
//
// A last beat sampled at edge k produces a one-cycle out_valid after edge k+3.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous, active-high; clears every register
//   in_valid   - qualifies in_first/in_last/in_a/in_b
//   in_first   - beat starts a new sum
//   in_last    - beat ends the sum and requests an output
//   in_a, in_b - signed operands
//   out        - rounded, saturated sum (holds between pulses)
//   out_valid  - one-cycle pulse qualifying out
//   out_sat    - saturation was applied to the current out

module mult_acc #(
    parameter int WL_A   = 16,
    parameter int WL_B   = 16,
    parameter int WL_ACC = 40,
    parameter int SHIFT  = 15,
    parameter int WL_OUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [WL_A-1:0]   in_a,
    input  logic signed [WL_B-1:0]   in_b,
    output logic signed [WL_OUT-1:0] out,
    output logic                     out_valid,
    output logic                     out_sat
);

    localparam int WL_P = WL_A + WL_B;
    localparam int WL_R = WL_ACC + 1;

    // Rounding constant 2^(SHIFT-1); zero when no shift is applied.
    localparam int              RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [WL_R-1:0] RND     = (SHIFT > 0) ? (WL_R'(1) << RND_POS) : '0;

    localparam logic signed [WL_OUT-1:0] OUT_MAX = {1'b0, {(WL_OUT-1){1'b1}}};
    localparam logic signed [WL_OUT-1:0] OUT_MIN = {1'b1, {(WL_OUT-1){1'b0}}};

    // ---------------------------------------------------------------- stage 1
    logic                   s1_valid;
    logic                   s1_first;
    logic                   s1_last;
    logic signed [WL_A-1:0] s1_a;
    logic signed [WL_B-1:0] s1_b;

    // Flags are gated by in_valid here so later stages only look at *_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_first <= in_valid & in_first;
            s1_last  <= in_valid & in_last;
            if (in_valid) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic                   s2_valid;
    logic                   s2_first;
    logic                   s2_last;
    logic signed [WL_P-1:0] s2_prod;
    logic signed [WL_P-1:0] prod;

    // Both operands signed, assigned to a full-width target: exact product.
    always_comb begin
        prod = s1_a * s1_b;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_prod <= prod;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic signed [WL_ACC-1:0] acc;
    logic signed [WL_ACC-1:0] prod_ext;
    logic                     s3_last;

    // Signed size cast sign-extends, and stays legal when WL_ACC == WL_P.
    always_comb begin
        prod_ext = WL_ACC'(s2_prod);
    end

    // Bubbles leave acc untouched. Overflow wraps; the output stage clamps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            s3_last <= 1'b0;
        end else begin
            s3_last <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_first) begin
                    acc <= prod_ext;
                end else begin
                    acc <= acc + prod_ext;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 4
    logic signed [WL_R-1:0]     acc_ext;
    logic signed [WL_R-1:0]     rnd_sum;
    logic signed [WL_R-1:0]     r;
    logic        [WL_R-WL_OUT:0] r_hi;
    logic                       r_fits;
    logic signed [WL_OUT-1:0]   sat_val;
    logic                       sat_flag;

    // The extra guard bit keeps the rounding add from overflowing.
    // r fits in WL_OUT bits exactly when every bit from the output sign
    // bit upward agrees.
    always_comb begin
        acc_ext = WL_R'(acc);
        rnd_sum = acc_ext + $signed(RND);
        r       = rnd_sum >>> SHIFT;
        r_hi    = r[WL_R-1:WL_OUT-1];
        r_fits  = (r_hi == '0) || (r_hi == '1);
        if (r_fits) begin
            sat_val  = r[WL_OUT-1:0];
            sat_flag = 1'b0;
        end else begin
            sat_val  = r[WL_R-1] ? OUT_MIN : OUT_MAX;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s3_last;
            if (s3_last) begin
                out     <= sat_val;
                out_sat <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_mult_acc.sv
// tb/tb_mult_acc.sv - self-checking bench for mult_acc (WL 8x8, acc 20, shift 4, out 8)

module tb_mult_acc;

    localparam int WL_A   = 8;
    localparam int WL_B   = 8;
    localparam int WL_ACC = 20;
    localparam int SHIFT  = 4;
    localparam int WL_OUT = 8;

    logic                     clock;
    logic                     reset;
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic signed [WL_A-1:0]   in_a;
    logic signed [WL_B-1:0]   in_b;
    logic signed [WL_OUT-1:0] out;
    logic                     out_valid;
    logic                     out_sat;

    mult_acc #(
        .WL_A(WL_A), .WL_B(WL_B), .WL_ACC(WL_ACC), .SHIFT(SHIFT), .WL_OUT(WL_OUT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .out(out), .out_valid(out_valid), .out_sat(out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct {
        int     due;
        longint val;
        bit     sat;
    } exp_t;

    exp_t   q[$];
    longint m_acc  = 0;
    longint m_hold = 0;
    bit     m_hsat = 1'b0;

    function automatic longint wrap_acc(input longint v);
        longint m;
        m = v & ((longint'(1) << WL_ACC) - 1);
        if (m >= (longint'(1) << (WL_ACC - 1)))
            m -= (longint'(1) << WL_ACC);
        return m;
    endfunction

    // Round half up by 2^SHIFT, i.e. floor((v + 2^(SHIFT-1)) / 2^SHIFT).
    function automatic longint round_shift(input longint v);
        longint s = v + (longint'(1) << (SHIFT - 1));
        longint d = longint'(1) << SHIFT;
        longint qt = s / d;
        if ((s % d != 0) && (s < 0)) qt -= 1;
        return qt;
    endfunction

    function automatic void model_beat(input bit first, input bit last, input int a, input int b);
        longint p = longint'(a) * longint'(b);
        longint r;
        exp_t   e;
        m_acc = first ? wrap_acc(p) : wrap_acc(m_acc + p);
        if (last) begin
            r = round_shift(m_acc);
            e.sat = 1'b1;
            if (r > 127)       e.val = 127;
            else if (r < -128) e.val = -128;
            else begin
                e.val = r;
                e.sat = 1'b0;
            end
            e.due = edge_cnt + 1 + 3;
            q.push_back(e);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_acc  = 0;
        m_hold = 0;
        m_hsat = 1'b0;
    endfunction

    // ------------------------------------------------------------ compare
    always @(negedge clock) begin
        bit exp_v;
        exp_v = (q.size() > 0) && (q[0].due == edge_cnt);
        chk("out_valid", longint'(out_valid), longint'(exp_v));
        if (exp_v) begin
            m_hold = q[0].val;
            m_hsat = q[0].sat;
            void'(q.pop_front());
        end
        chk("out", longint'($signed(out)), m_hold);
        chk("out_sat", longint'(out_sat), longint'(m_hsat));
    end

    // ------------------------------------------------------------ stimulus
    // Called just after a negedge; applies one beat, returns after the next negedge.
    task automatic drive(input bit v, input bit f, input bit l, input int a, input int b);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_a     = a[WL_A-1:0];
        in_b     = b[WL_B-1:0];
        if (v) model_beat(f, l, a, b);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Waits (bounded) for out_valid and pins out/out_sat and latency to literals.
    task automatic expect_pulse(input string name, input int k, input int exp_out, input bit exp_sat);
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        chk({name, " pulse"}, longint'(got), 1);
        if (got) begin
            chk({name, " latency"}, longint'(edge_cnt - k), 3);
            chk({name, " value"}, longint'($signed(out)), longint'(exp_out));
            chk({name, " sat"}, longint'(out_sat), longint'(exp_sat));
        end
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async out", longint'($signed(out)), 0);
        chk("async out_valid", longint'(out_valid), 0);
        chk("async out_sat", longint'(out_sat), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
        in_a = '0;
        in_b = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset out", longint'($signed(out)), 0);
        chk("reset out_valid", longint'(out_valid), 0);
        reset = 1'b0;

        // 3*5=15, (15+8)>>4 = 1
        k = edge_cnt + 1;
        drive(1, 1, 1, 3, 5);
        expect_pulse("single", k, 1, 0);
        idle(2);

        // 3*16384=49152, r=3072 -> clamp 127
        drive(1, 1, 0, -128, -128);
        drive(1, 0, 0, -128, -128);
        k = edge_cnt + 1;
        drive(1, 0, 1, -128, -128);
        expect_pulse("possat", k, 127, 1);
        idle(2);

        // (-63+8)>>>4 = -4
        k = edge_cnt + 1;
        drive(1, 1, 1, -7, 9);
        expect_pulse("neg", k, -4, 0);
        idle(2);

        // 16 + 16 = 32 -> 2, with two bubbles in between
        drive(1, 1, 0, 2, 8);
        idle(2);
        k = edge_cnt + 1;
        drive(1, 0, 1, 1, 16);
        expect_pulse("gap", k, 2, 0);
        idle(2);

        // Invalid beat carrying garbage flags/data must be ignored
        drive(1, 1, 0, 2, 8);
        drive(0, 1, 1, 99, 99);
        k = edge_cnt + 1;
        drive(1, 0, 1, 1, 16);
        expect_pulse("bubble", k, 2, 0);
        idle(2);

        // Reset with a last beat still in flight, then a fresh single beat
        drive(1, 1, 0, 5, 5);
        drive(1, 0, 1, 1, 1);
        pulse_reset();
        k = edge_cnt + 1;
        drive(1, 1, 1, 1, 16);
        expect_pulse("after_reset", k, 1, 0);
        idle(4);

        // Last with no first since reset accumulates onto 0: 32 -> 2
        pulse_reset();
        k = edge_cnt + 1;
        drive(1, 0, 1, 2, 16);
        expect_pulse("last_only", k, 2, 0);
        idle(2);

        // Back-to-back single sums on consecutive cycles
        k = edge_cnt + 1;
        drive(1, 1, 1, 16, 16);
        drive(1, 1, 1, -16, 16);
        expect_pulse("b2b first", k, 16, 0);
        idle(1);
        chk("b2b second valid", longint'(out_valid), 1);
        chk("b2b second value", longint'($signed(out)), -16);
        idle(2);

        // Last immediately followed by first of a new multi-beat sum
        drive(1, 1, 0, 10, 10);
        drive(1, 0, 1, 10, 10);
        drive(1, 1, 0, -100, 50);
        drive(1, 0, 0, -100, 50);
        k = edge_cnt + 1;
        drive(1, 0, 1, -100, 50);
        idle(6);

        // -16256*3 = -48768 -> r=-3048 -> clamp -128
        drive(1, 1, 0, -128, 127);
        drive(1, 0, 0, -128, 127);
        k = edge_cnt + 1;
        drive(1, 0, 1, -128, 127);
        expect_pulse("negsat", k, -128, 1);
        idle(2);

        // 32*16384 = 2^19 wraps the 20-bit accumulator to -2^19
        drive(1, 1, 0, -128, -128);
        for (int i = 0; i < 30; i++) drive(1, 0, 0, -128, -128);
        k = edge_cnt + 1;
        drive(1, 0, 1, -128, -128);
        expect_pulse("wrap", k, -128, 1);
        idle(2);

        // Boundary values that round exactly to the output limits
        drive(1, 1, 0, 127, 16);
        k = edge_cnt + 1;
        drive(1, 0, 1, 0, 0);
        expect_pulse("edge_max", k, 127, 0);
        k = edge_cnt + 1;
        drive(1, 1, 1, -128, 16);
        expect_pulse("edge_min", k, -128, 0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 SHALL have parameter WL_A, default 16, word length of in_a (signed).
REQ-002 SHALL have parameter WL_B, default 16, word length of in_b (signed).
REQ-003 SHALL have parameter WL_ACC, default 40, accumulator width; legal only if WL_ACC >= WL_A+WL_B.
REQ-004 SHALL have parameter SHIFT, default 15, right-shift applied to the accumulator at output; legal range 0..WL_ACC-1.
REQ-005 SHALL have parameter WL_OUT, default 16, output width; legal only if WL_OUT <= WL_ACC-SHIFT.
REQ-006 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1, qualifies the in_* beat.
REQ-009 SHALL have port in_first, input, 1, beat starts a new sum.
REQ-010 SHALL have port in_last, input, 1, beat ends the sum and requests output.
REQ-011 SHALL have port in_a, input, WL_A, signed operand.
REQ-012 SHALL have port in_b, input, WL_B, signed operand.
REQ-013 SHALL have port out, output, WL_OUT, signed rounded and saturated sum.
REQ-014 SHALL have port out_valid, output, 1, one-cycle pulse qualifying out.
REQ-015 SHALL have port out_sat, output, 1, saturation applied to the current out; valid only with out_valid.

Function
REQ-016 SHALL be a fully pipelined datapath with no back-pressure, accepting one beat per cycle.
REQ-017 Stage 1 SHALL register in_a, in_b, in_first and in_last, plus the valid bit.
REQ-018 Stage 2 SHALL register the full-precision signed product (WL_A+WL_B bits) with its flags.
REQ-019 Stage 3 SHALL update the accumulator: on first, acc = sign-extended product; otherwise acc = acc + product, wrapping modulo 2^WL_ACC.
REQ-020 Stage 4 SHALL, on a valid last beat, compute r = (acc_new + 2^(SHIFT-1)) >>> SHIFT (no add when SHIFT=0) in WL_ACC+1 bits, then saturate r to the signed WL_OUT range, and register out and out_sat.
REQ-021 Latency: a last beat sampled at edge k SHALL produce out_valid=1 in the cycle following edge k+3, for exactly one cycle.
REQ-022 out and out_sat SHALL hold their value between out_valid pulses.
REQ-023 in_first, in_last, in_a and in_b SHALL be ignored when in_valid=0; invalid bubbles SHALL leave the accumulator unchanged.
REQ-024 A beat with both in_first and in_last SHALL output the rounded, saturated value of that single product.
REQ-025 A beat with in_last and no in_first since reset SHALL accumulate onto 0.
REQ-026 A first beat immediately following a last beat SHALL start a fresh sum with no lost or merged cycle; results SHALL appear on consecutive cycles if the lasts are adjacent.
REQ-027 Saturation SHALL clamp to 2^(WL_OUT-1)-1 or -2^(WL_OUT-1) and SHALL set out_sat=1; otherwise out_sat=0.

Reset
REQ-028 On reset=1, all pipeline registers, valid bits, the accumulator, out, out_valid and out_sat SHALL go to 0 immediately, without waiting for a clock edge.
REQ-029 Reset mid-sum SHALL discard all in-flight beats and the partial sum; no out_valid SHALL result from beats accepted before reset.
REQ-030 The first edge after reset deassertion SHALL accept a beat normally.

Verification (WL_A=WL_B=8, WL_ACC=20, SHIFT=4, WL_OUT=8)
REQ-031 Single beat, first+last, a=3, b=5 -> out=1, out_sat=0, with out_valid exactly 3 edges after sampling.
REQ-032 Three beats of a=-128, b=-128 -> sum 49152, r=3072 -> out=127, out_sat=1.
REQ-033 Single beat a=-7, b=9 -> (-63+8)>>>4 -> out=-4 (0xFC), out_sat=0.
REQ-034 Beat first a=2, b=8; two idle cycles; beat last a=1, b=16 -> out=2, one out_valid pulse.
REQ-035 Reset asserted between first and last beats, then first+last a=1, b=16 -> single out_valid, out=1.
REQ-036 Back-to-back single-beat sums a=16, b=16 then a=-16, b=16 -> out=16 then out=-16 on consecutive cycles.
